// File: rtl/cpu_pkg.sv
// Shared MIPS32 pipeline constants: datapath widths, control-bundle bit positions,
// ALU op encodings and the operand bypass select used in the decode stage.
package cpu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned CTRL_W   = 8;
  localparam int unsigned ALU_OP_W = 4;

  localparam int unsigned CTRL_REG_WRITE  = 0;
  localparam int unsigned CTRL_MEM_READ   = 1;
  localparam int unsigned CTRL_MEM_WRITE  = 2;
  localparam int unsigned CTRL_MEM_TO_REG = 3;
  localparam int unsigned CTRL_ALU_SRC    = 4;
  localparam int unsigned CTRL_REG_DST    = 5;
  localparam int unsigned CTRL_USES_RT    = 6;
  localparam int unsigned CTRL_RESERVED   = 7;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  typedef enum logic [ALU_OP_W-1:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluNor = 4'd5,
    AluSlt = 4'd6,
    AluSll = 4'd7,
    AluSrl = 4'd8,
    AluSra = 4'd9,
    AluLui = 4'd10
  } alu_op_e;

  // A load still in MEM has no data yet, so it is never a bypass source.
  function automatic logic [DATA_W-1:0] fwd_select(
    input logic [REG_AW-1:0] src,
    input logic [DATA_W-1:0] rf_data,
    input logic              exmem_wr,
    input logic              exmem_ld,
    input logic [REG_AW-1:0] exmem_rd,
    input logic [DATA_W-1:0] exmem_res,
    input logic              memwb_wr,
    input logic [REG_AW-1:0] memwb_rd,
    input logic [DATA_W-1:0] memwb_res
  );
    if (src == '0) begin
      return '0;
    end else if (exmem_wr && !exmem_ld && (exmem_rd == src)) begin
      return exmem_res;
    end else if (memwb_wr && (memwb_rd == src)) begin
      return memwb_res;
    end else begin
      return rf_data;
    end
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: decode inputs, downstream bypass sources, flush, and the ID/EX latch outputs.
// The slave modport is the stage itself; the master drives it.
interface id_ex_stage_if;
  import cpu_pkg::*;

  logic                id_valid;
  logic [DATA_W-1:0]   id_pc;
  logic [REG_AW-1:0]   id_rs;
  logic [REG_AW-1:0]   id_rt;
  logic [REG_AW-1:0]   id_rd;
  logic [DATA_W-1:0]   id_imm;
  logic [CTRL_W-1:0]   id_ctrl;
  logic [ALU_OP_W-1:0] id_alu_op;
  logic [DATA_W-1:0]   rf_data_1;
  logic [DATA_W-1:0]   rf_data_2;
  logic                exmem_reg_write;
  logic                exmem_mem_read;
  logic [REG_AW-1:0]   exmem_rd;
  logic [DATA_W-1:0]   exmem_result;
  logic                memwb_reg_write;
  logic [REG_AW-1:0]   memwb_rd;
  logic [DATA_W-1:0]   memwb_result;
  logic                flush;

  logic                hazard_stall;
  logic                ex_valid;
  logic [DATA_W-1:0]   ex_pc;
  logic [DATA_W-1:0]   ex_op_a;
  logic [DATA_W-1:0]   ex_op_b;
  logic [DATA_W-1:0]   ex_imm;
  logic [REG_AW-1:0]   ex_rd;
  logic [CTRL_W-1:0]   ex_ctrl;
  logic [ALU_OP_W-1:0] ex_alu_op;

  modport master (
    output id_valid, id_pc, id_rs, id_rt, id_rd, id_imm, id_ctrl, id_alu_op,
    output rf_data_1, rf_data_2,
    output exmem_reg_write, exmem_mem_read, exmem_rd, exmem_result,
    output memwb_reg_write, memwb_rd, memwb_result, flush,
    input  hazard_stall, ex_valid, ex_pc, ex_op_a, ex_op_b, ex_imm, ex_rd, ex_ctrl, ex_alu_op
  );

  modport slave (
    input  id_valid, id_pc, id_rs, id_rt, id_rd, id_imm, id_ctrl, id_alu_op,
    input  rf_data_1, rf_data_2,
    input  exmem_reg_write, exmem_mem_read, exmem_rd, exmem_result,
    input  memwb_reg_write, memwb_rd, memwb_result, flush,
    output hazard_stall, ex_valid, ex_pc, ex_op_a, ex_op_b, ex_imm, ex_rd, ex_ctrl, ex_alu_op
  );

endinterface

// File: rtl/id_ex_stage_hazard_fwd_unit.sv
// Combinational operand bypass select and hazard detect for the ID stage.
// Flags sources whose producer is still in EX, or is a load still in MEM.
module hazard_fwd_unit
  import cpu_pkg::*;
(
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_uses_rt,
  input  logic [DATA_W-1:0] i_rf_data_1,
  input  logic [DATA_W-1:0] i_rf_data_2,
  input  logic              i_exmem_reg_write,
  input  logic              i_exmem_mem_read,
  input  logic [REG_AW-1:0] i_exmem_rd,
  input  logic [DATA_W-1:0] i_exmem_result,
  input  logic              i_memwb_reg_write,
  input  logic [REG_AW-1:0] i_memwb_rd,
  input  logic [DATA_W-1:0] i_memwb_result,
  input  logic              i_ex_valid,
  input  logic              i_ex_reg_write,
  input  logic [REG_AW-1:0] i_ex_rd,
  output logic [DATA_W-1:0] o_op_a,
  output logic [DATA_W-1:0] o_op_b,
  output logic              o_hazard
);

  logic w_ex_wr;
  logic w_mem_ld;
  logic w_rs_hazard;
  logic w_rt_hazard;

  assign w_ex_wr  = i_ex_valid & i_ex_reg_write;
  assign w_mem_ld = i_exmem_reg_write & i_exmem_mem_read;

  always_comb begin
    o_op_a = fwd_select(i_id_rs, i_rf_data_1, i_exmem_reg_write, i_exmem_mem_read, i_exmem_rd,
                        i_exmem_result, i_memwb_reg_write, i_memwb_rd, i_memwb_result);
    o_op_b = fwd_select(i_id_rt, i_rf_data_2, i_exmem_reg_write, i_exmem_mem_read, i_exmem_rd,
                        i_exmem_result, i_memwb_reg_write, i_memwb_rd, i_memwb_result);
  end

  always_comb begin
    w_rs_hazard = (i_id_rs != '0) &&
                  ((w_ex_wr && (i_ex_rd == i_id_rs)) || (w_mem_ld && (i_exmem_rd == i_id_rs)));
    w_rt_hazard = i_uses_rt && (i_id_rt != '0) &&
                  ((w_ex_wr && (i_ex_rd == i_id_rt)) || (w_mem_ld && (i_exmem_rd == i_id_rt)));
    o_hazard    = i_id_valid & (w_rs_hazard | w_rt_hazard);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline latch: captures the decoded instruction with bypassed operands,
// or a bubble on flush/stall. Stall goes back to PC and IF/ID.
module id_ex_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  id_ex_stage_if.slave  bus
);

  logic [DATA_W-1:0]   w_op_a;
  logic [DATA_W-1:0]   w_op_b;
  logic                w_hazard;
  logic                w_stall;
  logic [REG_AW-1:0]   w_dest;

  logic                r_valid;
  logic [DATA_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_imm;
  logic [REG_AW-1:0]   r_rd;
  logic [CTRL_W-1:0]   r_ctrl;
  logic [ALU_OP_W-1:0] r_alu_op;

  hazard_fwd_unit u_hazard_fwd_unit (
    .i_id_valid        (bus.id_valid),
    .i_id_rs           (bus.id_rs),
    .i_id_rt           (bus.id_rt),
    .i_uses_rt         (bus.id_ctrl[CTRL_USES_RT]),
    .i_rf_data_1       (bus.rf_data_1),
    .i_rf_data_2       (bus.rf_data_2),
    .i_exmem_reg_write (bus.exmem_reg_write),
    .i_exmem_mem_read  (bus.exmem_mem_read),
    .i_exmem_rd        (bus.exmem_rd),
    .i_exmem_result    (bus.exmem_result),
    .i_memwb_reg_write (bus.memwb_reg_write),
    .i_memwb_rd        (bus.memwb_rd),
    .i_memwb_result    (bus.memwb_result),
    .i_ex_valid        (r_valid),
    .i_ex_reg_write    (r_ctrl[CTRL_REG_WRITE]),
    .i_ex_rd           (r_rd),
    .o_op_a            (w_op_a),
    .o_op_b            (w_op_b),
    .o_hazard          (w_hazard)
  );

  // A taken branch kills the stalled instruction anyway, so no point holding IF/ID.
  assign w_stall = w_hazard & ~bus.flush & ~reset;
  assign w_dest  = bus.id_ctrl[CTRL_REG_DST] ? bus.id_rd : bus.id_rt;

  always_ff @(posedge clk) begin
    if (reset || bus.flush || w_stall) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_imm    <= '0;
      r_rd     <= '0;
      r_ctrl   <= BUBBLE_CTRL;
      r_alu_op <= '0;
    end else begin
      r_valid  <= bus.id_valid;
      r_pc     <= bus.id_pc;
      r_op_a   <= w_op_a;
      r_op_b   <= w_op_b;
      r_imm    <= bus.id_imm;
      r_rd     <= w_dest;
      r_ctrl   <= bus.id_valid ? bus.id_ctrl : BUBBLE_CTRL;
      r_alu_op <= bus.id_alu_op;
    end
  end

  assign bus.hazard_stall = w_stall;
  assign bus.ex_valid     = r_valid;
  assign bus.ex_pc        = r_pc;
  assign bus.ex_op_a      = r_op_a;
  assign bus.ex_op_b      = r_op_b;
  assign bus.ex_imm       = r_imm;
  assign bus.ex_rd        = r_rd;
  assign bus.ex_ctrl      = r_ctrl;
  assign bus.ex_alu_op    = r_alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: single-cycle vector table applied after a reset, then
// hand-written multi-cycle sequences for stalls, load-use, flush and reset.
module tb_id_ex_stage;
  import cpu_pkg::*;

  localparam logic [7:0] CtrlR    = 8'h61;  // reg_write, reg_dst, uses_rt
  localparam logic [7:0] CtrlAddi = 8'h11;  // reg_write, alu_src
  localparam logic [7:0] CtrlLw   = 8'h1B;  // reg_write, mem_read, mem_to_reg, alu_src
  localparam logic [7:0] CtrlSw   = 8'h54;  // mem_write, alu_src, uses_rt

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic [3:0]  op;
    logic [31:0] rf1, rf2;
    logic        xw, xm;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic        fl;
    logic        e_stall, e_valid;
    logic [31:0] e_a, e_b;
    logic [4:0]  e_rd;
    logic [7:0]  e_ctrl;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage u_dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_pc = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_imm = '0; bus.id_ctrl = '0; bus.id_alu_op = '0;
    bus.rf_data_1 = '0; bus.rf_data_2 = '0;
    bus.exmem_reg_write = 1'b0; bus.exmem_mem_read = 1'b0; bus.exmem_rd = '0;
    bus.exmem_result = '0;
    bus.memwb_reg_write = 1'b0; bus.memwb_rd = '0; bus.memwb_result = '0;
    bus.flush = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm, input logic [7:0] ctrl);
    bus.id_valid = 1'b1; bus.id_pc = pc; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_imm = imm; bus.id_ctrl = ctrl; bus.id_alu_op = 4'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input vec_t v);
    bus.id_valid = v.valid; bus.id_pc = v.pc; bus.id_rs = v.rs; bus.id_rt = v.rt;
    bus.id_rd = v.rd; bus.id_imm = v.imm; bus.id_ctrl = v.ctrl; bus.id_alu_op = v.op;
    bus.rf_data_1 = v.rf1; bus.rf_data_2 = v.rf2;
    bus.exmem_reg_write = v.xw; bus.exmem_mem_read = v.xm; bus.exmem_rd = v.xrd;
    bus.exmem_result = v.xres;
    bus.memwb_reg_write = v.ww; bus.memwb_rd = v.wrd; bus.memwb_result = v.wres;
    bus.flush = v.fl;
  endtask

  initial begin
    // valid pc rs rt rd imm ctrl op rf1 rf2 | xw xm xrd xres | ww wrd wres | fl
    // | stall valid a b rd ctrl
    tbl[0]  = '{1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h0, CtrlR, 4'd0, 32'h11, 32'h22,
                1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0,
                1'b0, 1'b1, 32'h11, 32'h22, 5'd3, CtrlR};
    tbl[1]  = '{1'b1, 32'h104, 5'd7, 5'd7, 5'd9, 32'h0, CtrlR, 4'd1, 32'h77, 32'h77,
                1'b1, 1'b0, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 1'b0,
                1'b0, 1'b1, 32'h1, 32'h1, 5'd9, CtrlR};
    tbl[2]  = '{1'b1, 32'h108, 5'd0, 5'd0, 5'd3, 32'h0, CtrlR, 4'd0, 32'h55, 32'h66,
                1'b1, 1'b0, 5'd0, 32'h1, 1'b1, 5'd0, 32'h2, 1'b0,
                1'b0, 1'b1, 32'h0, 32'h0, 5'd3, CtrlR};
    tbl[3]  = '{1'b1, 32'h10c, 5'd4, 5'd5, 5'd6, 32'h0, CtrlR, 4'd2, 32'h44, 32'h5,
                1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'hCAFE, 1'b0,
                1'b0, 1'b1, 32'hCAFE, 32'h5, 5'd6, CtrlR};
    tbl[4]  = '{1'b1, 32'h110, 5'd8, 5'd2, 5'd3, 32'h0, CtrlR, 4'd0, 32'h88, 32'h22,
                1'b1, 1'b1, 5'd8, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0,
                1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 8'h00};
    tbl[5]  = '{1'b1, 32'h114, 5'd3, 5'd6, 5'd0, 32'h5, CtrlAddi, 4'd0, 32'h33, 32'h66,
                1'b1, 1'b1, 5'd6, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0,
                1'b0, 1'b1, 32'h33, 32'h66, 5'd6, CtrlAddi};
    tbl[6]  = '{1'b1, 32'h110, 5'd8, 5'd2, 5'd3, 32'h0, CtrlR, 4'd0, 32'h88, 32'h22,
                1'b1, 1'b1, 5'd8, 32'h99, 1'b0, 5'd0, 32'h0, 1'b1,
                1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 8'h00};
    tbl[7]  = '{1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'h0, CtrlR, 4'd3, 32'h11, 32'h22,
                1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1,
                1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 8'h00};
    tbl[8]  = '{1'b0, 32'h118, 5'd8, 5'd2, 5'd3, 32'h0, CtrlR, 4'd0, 32'h88, 32'h22,
                1'b1, 1'b1, 5'd8, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0,
                1'b0, 1'b0, 32'h88, 32'h22, 5'd3, 8'h00};
    tbl[9]  = '{1'b1, 32'h11c, 5'd1, 5'd8, 5'd0, 32'h4, CtrlSw, 4'd0, 32'h11, 32'h88,
                1'b1, 1'b1, 5'd8, 32'h99, 1'b0, 5'd0, 32'h0, 1'b0,
                1'b1, 1'b0, 32'h0, 32'h0, 5'd0, 8'h00};
    tbl[10] = '{1'b1, 32'h120, 5'd9, 5'd8, 5'd31, 32'h8, CtrlLw, 4'd0, 32'h90, 32'h80,
                1'b1, 1'b0, 5'd9, 32'h1234, 1'b1, 5'd9, 32'h5678, 1'b0,
                1'b0, 1'b1, 32'h1234, 32'h80, 5'd8, CtrlLw};
    tbl[11] = '{1'b1, 32'h124, 5'd10, 5'd11, 5'd12, 32'h0, CtrlR, 4'd3, 32'hA, 32'hB,
                1'b0, 1'b0, 5'd10, 32'h1, 1'b1, 5'd11, 32'h2, 1'b0,
                1'b0, 1'b1, 32'hA, 32'h2, 5'd12, CtrlR};

    // Reset with a valid instruction and a live hazard presented
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    issue(32'h40, 5'd1, 5'd2, 5'd3, 32'h0, CtrlR);
    tick();
    chk("pre_reset_ex_valid", 32'(bus.ex_valid), 32'd1);
    issue(32'h44, 5'd3, 5'd5, 5'd4, 32'h0, CtrlR);
    #1;
    chk("pre_reset_stall", 32'(bus.hazard_stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_stall_forced_0", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("reset_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("reset_ex_pc", bus.ex_pc, 32'd0);
    chk("reset_ex_rd", 32'(bus.ex_rd), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_reset();
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(bus.hazard_stall), 32'(tbl[i].e_stall));
      tick();
      chk($sformatf("v%0d_valid", i), 32'(bus.ex_valid), 32'(tbl[i].e_valid));
      chk($sformatf("v%0d_op_a", i), bus.ex_op_a, tbl[i].e_a);
      chk($sformatf("v%0d_op_b", i), bus.ex_op_b, tbl[i].e_b);
      chk($sformatf("v%0d_rd", i), 32'(bus.ex_rd), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d_ctrl", i), 32'(bus.ex_ctrl), 32'(tbl[i].e_ctrl));
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), bus.ex_pc, tbl[i].pc);
        chk($sformatf("v%0d_imm", i), bus.ex_imm, tbl[i].imm);
        chk($sformatf("v%0d_alu_op", i), 32'(bus.ex_alu_op), 32'(tbl[i].op));
      end else if (tbl[i].valid) begin
        chk($sformatf("v%0d_bubble_alu_op", i), 32'(bus.ex_alu_op), 32'd0);
        chk($sformatf("v%0d_bubble_pc", i), bus.ex_pc, 32'd0);
      end
    end

    // Distance-1 ALU producer: add $3,$1,$2 then sub $4,$3,$5
    do_reset();
    issue(32'h200, 5'd1, 5'd2, 5'd3, 32'h0, CtrlR);
    #1;
    chk("alu1_add_stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    issue(32'h204, 5'd3, 5'd5, 5'd4, 32'h0, CtrlR);
    bus.rf_data_2 = 32'h5;
    #1;
    chk("alu1_stall_c1", 32'(bus.hazard_stall), 32'd1);
    tick();
    chk("alu1_bubble_valid", 32'(bus.ex_valid), 32'd0);
    chk("alu1_bubble_ctrl", 32'(bus.ex_ctrl), 32'd0);
    bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h10;
    #1;
    chk("alu1_stall_c2", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("alu1_issue_valid", 32'(bus.ex_valid), 32'd1);
    chk("alu1_issue_op_a", bus.ex_op_a, 32'h10);
    chk("alu1_issue_op_b", bus.ex_op_b, 32'h5);
    chk("alu1_issue_rd", 32'(bus.ex_rd), 32'd4);

    // Load-use: lw $8,0($9) then add $10,$8,$8
    do_reset();
    issue(32'h300, 5'd9, 5'd8, 5'd0, 32'h0, CtrlLw);
    tick();
    chk("lu_lw_ex_rd", 32'(bus.ex_rd), 32'd8);
    issue(32'h304, 5'd8, 5'd8, 5'd10, 32'h0, CtrlR);
    #1;
    chk("lu_stall_c1", 32'(bus.hazard_stall), 32'd1);
    tick();
    bus.exmem_reg_write = 1'b1; bus.exmem_mem_read = 1'b1; bus.exmem_rd = 5'd8;
    bus.exmem_result = 32'h300;
    #1;
    chk("lu_stall_c2", 32'(bus.hazard_stall), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
    bus.exmem_reg_write = 1'b0; bus.exmem_mem_read = 1'b0; bus.exmem_rd = 5'd0;
    bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd8; bus.memwb_result = 32'hDEADBEEF;
    #1;
    chk("lu_stall_c3", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("lu_issue_valid", 32'(bus.ex_valid), 32'd1);
    chk("lu_issue_op_a", bus.ex_op_a, 32'hDEADBEEF);
    chk("lu_issue_op_b", bus.ex_op_b, 32'hDEADBEEF);
    chk("lu_issue_rd", 32'(bus.ex_rd), 32'd10);

    // Flush on top of a distance-1 hazard
    do_reset();
    issue(32'h400, 5'd1, 5'd2, 5'd3, 32'h0, CtrlR);
    tick();
    issue(32'h404, 5'd3, 5'd5, 5'd4, 32'h0, CtrlR);
    bus.flush = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);

    // rt unused: addi $2,$3,5 in EX, then addi with rt=$2, rs=$4
    do_reset();
    issue(32'h500, 5'd3, 5'd2, 5'd0, 32'h5, CtrlAddi);
    tick();
    issue(32'h504, 5'd4, 5'd2, 5'd0, 32'h5, CtrlAddi);
    #1;
    chk("rtu_stall", 32'(bus.hazard_stall), 32'd0);
    tick();
    chk("rtu_ex_valid", 32'(bus.ex_valid), 32'd1);
    chk("rtu_ex_imm", bus.ex_imm, 32'h5);
    chk("rtu_ex_rd", 32'(bus.ex_rd), 32'd2);
    issue(32'h508, 5'd1, 5'd2, 5'd6, 32'h0, CtrlR);
    #1;
    chk("rtu_used_rt_stall", 32'(bus.hazard_stall), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the MIPS32 pipelined core, directly downstream of the register file.
- Consumes the two register-file read ports, resolves operands by bypass from EX/MEM and MEM/WB, and detects data hazards that bypass cannot cover.
- Registers a decoded instruction into the ID/EX latch, or a bubble in its place, for the EX stage.
- Drives the stall back to PC/IF-ID and honours branch flush from EX.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register address width (32 registers, $0 hardwired zero)
CTRL_W, 8, control bundle width; field positions defined in shared package

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high; clears all state
id_valid  input  1  IF/ID holds a real instruction
id_pc  input  32  PC of ID instruction
id_rs  input  5  source register 1 (also drives register-file read_addr_1 externally)
id_rt  input  5  source register 2 (also drives register-file read_addr_2 externally)
id_rd  input  5  R-type destination
id_imm  input  32  sign-extended immediate
id_ctrl  input  8  [0]reg_write [1]mem_read [2]mem_write [3]mem_to_reg [4]alu_src [5]reg_dst [6]uses_rt [7]reserved
id_alu_op  input  4  ALU operation
rf_data_1  input  32  register-file read_data_1
rf_data_2  input  32  register-file read_data_2
exmem_reg_write  input  1  EX/MEM instruction writes a register
exmem_mem_read  input  1  EX/MEM instruction is a load
exmem_rd  input  5  EX/MEM destination
exmem_result  input  32  EX/MEM ALU result
memwb_reg_write  input  1  MEM/WB writes a register
memwb_rd  input  5  MEM/WB destination
memwb_result  input  32  final write-back value
flush  input  1  branch taken in EX; kill ID instruction
hazard_stall  output  1  hold PC and IF/ID this cycle
ex_valid  output  1  ID/EX holds a real instruction
ex_pc  output  32  registered PC
ex_op_a  output  32  resolved rs value
ex_op_b  output  32  resolved rt value (store data / ALU B before imm mux)
ex_imm  output  32  registered immediate
ex_rd  output  5  final destination: reg_dst ? id_rd : id_rt
ex_ctrl  output  8  registered control bundle
ex_alu_op  output  4  registered ALU op

Behaviour:
- Reset (sync): every ex_* output is 0, ex_valid = 0, ex_ctrl = 0. hazard_stall is combinational and is forced to 0 while reset is high.
- Operand resolution (combinational, per source s in {rs, rt}), in priority order:
  1. s == 0 → 0.
  2. exmem_reg_write & exmem_rd == s & !exmem_mem_read → exmem_result.
  3. memwb_reg_write & memwb_rd == s → memwb_result.
  4. Otherwise the register-file data.
- The register file writes on the falling edge. The MEM/WB bypass is still mandatory.
- There is no EX→ID bypass. A hazard exists when id_valid and a used source (rs always; rt only if id_ctrl[6]) is non-zero and either:
  - (a) ex_valid & ex_ctrl[0] & ex_rd == source (distance 1, any producer), or
  - (b) exmem_reg_write & exmem_mem_read & exmem_rd == source (load in MEM).
- Resulting stalls: an ALU producer at distance 1 costs 1 stall cycle. A load at distance 1 costs 2 stall cycles.
- hazard_stall = hazard & !flush.
- Rising edge, with priority reset > flush > hazard_stall > normal:
  - flush: load a bubble (ex_valid = 0, ex_ctrl = 0, ex_alu_op = 0; data fields don't-care, implement as 0).
  - hazard_stall: load a bubble. IF/ID holds externally, so the same instruction re-evaluates next cycle.
  - normal: capture id_* fields, resolved operands and ex_rd. If id_valid = 0, capture ex_valid = 0 and ex_ctrl = 0.
- Latency: 1 cycle ID→EX, with no combinational path from id_* to ex_* outputs.
- Reset mid-stall: the bubble is dropped and hazard_stall is 0 the same cycle.

Decomposition:
- Package cpu_pkg: CTRL_* bit indices, ALU_OP encodings, DATA_W/REG_AW constants, BUBBLE_CTRL = 0.
- One sub-module, hazard_fwd_unit: purely combinational operand select plus the hazard detect. id_ex_stage holds only the register and its priority logic.

Test Plan:
- Reset: assert reset with id_valid = 1 → next edge ex_valid = 0, ex_ctrl = 0, hazard_stall = 0.
- Distance 1 ALU: `add $3,$1,$2`, then `sub $4,$3,$5`.
  - Required: hazard_stall = 1 for exactly 1 cycle, then a bubble in EX.
  - Next issue (add now in EX/MEM, exmem_result = 0x10): ex_op_a = 0x10.
- Load-use: `lw $8,0($9)`, then `add $10,$8,$8`.
  - Required: 2 stall cycles.
  - Then ex_op_a = ex_op_b = memwb_result (0xDEADBEEF) while rf_data_1 = 0.
- Priority: exmem and memwb both target $7 (0x1 vs 0x2), ID reads $7 → ex_op_a = 0x1. With id_rs = 0 and both targeting $0 → ex_op_a = 0.
- Flush during stall: hazard condition plus flush = 1 → hazard_stall = 0, next ex_valid = 0.
- rt unused: `addi $2,$3,5` with ex_rd = $2 in EX. An ID `addi` whose rt = $2 but rs = $4 (uses_rt = 0) → no stall, ex_imm = 0x5, ex_rd = id_rt.
